// File: rtl/mem_pkg.sv
// Shared sizes, self-test seed and controller state encoding for the memory host controller.
package mem_pkg;

   localparam int unsigned ADDR_W    = 3;
   localparam int unsigned DATA_W    = 16;
   localparam logic [15:0] BIST_SEED = 16'hA5A5;

   typedef enum logic [3:0] {
      IDLE,
      WR,
      RD_ADDR,
      RD_CAP,
      RSP,
      BIST_WR,
      BIST_RD,
      BIST_CMP,
      BIST_END
   } state_t;

endpackage

// File: rtl/mem_pattern_gen.sv
// Self-test data pattern: seed XOR address, inverted on the second pass.
module mem_pattern_gen #(
   parameter int unsigned               ADDR_W = 3,
   parameter int unsigned               DATA_W = 16,
   parameter logic [DATA_W-1:0]         SEED   = DATA_W'(16'hA5A5)
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              pass,
   output logic [DATA_W-1:0] word
);

   logic [DATA_W-1:0] base;

   assign base = SEED ^ DATA_W'(addr);
   assign word = pass ? ~base : base;

endmodule

// File: rtl/mem_host_ctrl.sv
// Host command front-end for a small synchronous memory, with a two-pass built-in self-test.
module mem_host_ctrl #(
   parameter int unsigned       ADDR_W    = mem_pkg::ADDR_W,
   parameter int unsigned       DATA_W    = mem_pkg::DATA_W,
   parameter logic [DATA_W-1:0] BIST_SEED = DATA_W'(mem_pkg::BIST_SEED)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   input  logic              bist_start,
   output logic              bist_busy,
   output logic              bist_done,
   output logic              bist_fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   import mem_pkg::*;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              pass_q, pass_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              fail_q, fail_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0] pattern;
   logic              last_addr;

   mem_pattern_gen #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .SEED   (BIST_SEED)
   ) u_pattern (
      .addr (addr_q),
      .pass (pass_q),
      .word (pattern)
   );

   assign last_addr = &addr_q;
   assign mem_addr  = addr_q;
   assign rsp_data  = rsp_data_q;
   assign bist_fail = fail_q;
   assign fail_addr = fail_addr_q;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         pass_q      <= 1'b0;
         rsp_data_q  <= '0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         pass_q      <= pass_d;
         rsp_data_q  <= rsp_data_d;
         fail_q      <= fail_d;
         fail_addr_q <= fail_addr_d;
      end
   end

   // Next-state, datapath updates and state-decoded outputs
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      pass_d      = pass_q;
      rsp_data_d  = rsp_data_q;
      fail_d      = fail_q;
      fail_addr_d = fail_addr_q;
      cmd_ready   = 1'b0;
      rsp_valid   = 1'b0;
      bist_busy   = 1'b0;
      bist_done   = 1'b0;
      mem_cs      = 1'b0;
      mem_we      = 1'b0;
      mem_din     = data_q;

      unique case (state_q)
         IDLE: begin
            // Self-test has priority over a simultaneous host command
            if (bist_start) begin
               state_d     = BIST_WR;
               addr_d      = '0;
               pass_d      = 1'b0;
               fail_d      = 1'b0;
               fail_addr_d = '0;
            end else begin
               cmd_ready = rst_n;
               if (cmd_valid) begin
                  addr_d  = cmd_addr;
                  data_d  = cmd_data;
                  state_d = cmd_we ? WR : RD_ADDR;
               end
            end
         end
         WR: begin
            mem_cs  = 1'b1;
            mem_we  = 1'b1;
            state_d = IDLE;
         end
         RD_ADDR: begin
            mem_cs  = 1'b1;
            state_d = RD_CAP;
         end
         RD_CAP: begin
            rsp_data_d = mem_dout;
            state_d    = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         BIST_WR: begin
            bist_busy = 1'b1;
            mem_cs    = 1'b1;
            mem_we    = 1'b1;
            mem_din   = pattern;
            addr_d    = addr_q + ADDR_W'(1);
            if (last_addr) begin
               state_d = BIST_RD;
            end
         end
         BIST_RD: begin
            bist_busy = 1'b1;
            mem_cs    = 1'b1;
            state_d   = BIST_CMP;
         end
         BIST_CMP: begin
            bist_busy = 1'b1;
            // Address wraps to 0 through the increment at the end of each pass
            if (mem_dout != pattern) begin
               fail_d      = 1'b1;
               fail_addr_d = addr_q;
               state_d     = BIST_END;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
               if (!last_addr) begin
                  state_d = BIST_RD;
               end else if (pass_q) begin
                  state_d = BIST_END;
               end else begin
                  pass_d  = 1'b1;
                  state_d = BIST_WR;
               end
            end
         end
         BIST_END: begin
            bist_done = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_host_ctrl.sv
// Randomised self-checking bench for mem_host_ctrl against a word-array reference model.
module tb_mem_host_ctrl;

   import mem_pkg::*;

   localparam int unsigned AW = ADDR_W;
   localparam int unsigned DW = DATA_W;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          bist_start;
   logic          bist_busy;
   logic          bist_done;
   logic          bist_fail;
   logic [AW-1:0] fail_addr;
   logic          mem_cs;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   logic [DW-1:0] mem     [8];
   logic [DW-1:0] ref_mem [8];
   logic          fault;
   int            n_checks;
   int            n_errors;

   mem_host_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_we     (cmd_we),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .bist_start (bist_start),
      .bist_busy  (bist_busy),
      .bist_done  (bist_done),
      .bist_fail  (bist_fail),
      .fail_addr  (fail_addr),
      .mem_cs     (mem_cs),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous memory; optional stuck-at-1 on bit 0 of word 5
   always @(posedge clk) begin
      if (mem_cs && mem_we) mem[mem_addr] <= mem_din;
      if (mem_cs && !mem_we) mem_dout <= mem[mem_addr] | ((fault && mem_addr == 3'd5) ? 16'h0001 : 16'h0000);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int a, input bit p);
      logic [DW-1:0] w;
      w = BIST_SEED ^ DW'(a);
      return p ? ~w : w;
   endfunction

   function automatic logic [63:0] outs();
      return 64'({cmd_ready, rsp_valid, rsp_data, mem_cs, mem_we, mem_addr, mem_din,
                  bist_busy, bist_done, bist_fail, fail_addr});
   endfunction

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = a; cmd_data = d;
      #1 check("wr_ready", 64'(cmd_ready), 64'(1));
      @(posedge clk); #1;
      check("wr_strobe", 64'({mem_cs, mem_we, mem_addr, mem_din}), 64'({2'b11, a, d}));
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("wr_back_idle", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
      ref_mem[a] = d;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int hold);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = a; cmd_data = DW'($urandom);
      #1 check("rd_ready", 64'(cmd_ready), 64'(1));
      @(posedge clk); #1;
      check("rd_addr", 64'({mem_cs, mem_we, mem_addr}), 64'({2'b10, a}));
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("rd_cap_novalid", 64'(rsp_valid), 64'(0));
      @(posedge clk); #1;
      check("rd_rsp", 64'({rsp_valid, rsp_data}), 64'({1'b1, ref_mem[a]}));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("rd_hold", 64'({rsp_valid, rsp_data, cmd_ready}), 64'({1'b1, ref_mem[a], 1'b0}));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("rd_done", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
   endtask

   task automatic do_bist(input bit with_cmd, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
      int          exp_busy = 48;
      bit          exp_fail = 1'b0;
      int          exp_faddr = 0;
      int          fpass = 1;
      int          cyc = 0;
      int          busy = 0;
      int          done_at = 0;
      int          stray = 0;
      logic [DW-1:0] w;
      if (fault) begin
         for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 8; a++) begin
               w = pat(a, p[0]);
               if (!exp_fail && a == 5 && w[0] == 1'b0) begin
                  exp_fail = 1'b1; exp_faddr = a; fpass = p;
                  exp_busy = p * 24 + 8 + 2 * (a + 1);
               end
            end
         end
      end
      bist_start = 1'b1;
      if (with_cmd) begin
         cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = ca; cmd_data = cd;
      end
      #1 check("bist_acc_noready", 64'(cmd_ready), 64'(0));
      while (done_at == 0 && cyc < 120) begin
         @(posedge clk); #1;
         bist_start = 1'b0;
         cyc++;
         if (cyc == 1) check("bist_clear", 64'({bist_fail, fail_addr}), 64'(0));
         if (bist_busy) busy++;
         if (bist_done) done_at = cyc;
         if (cmd_ready) stray++;
      end
      check("bist_done_cycle", 64'(done_at), 64'(exp_busy + 1));
      check("bist_busy_cycles", 64'(busy), 64'(exp_busy));
      check("bist_result", 64'({bist_fail, fail_addr}), 64'({exp_fail, AW'(exp_faddr)}));
      check("bist_no_ready", 64'(stray), 64'(0));
      for (int a = 0; a < 8; a++) ref_mem[a] = pat(a, fpass[0]);
      @(posedge clk); #1;
      check("bist_done_pulse", 64'({bist_done, bist_busy}), 64'(0));
      if (with_cmd) begin
         check("bist_cmd_after", 64'(cmd_ready), 64'(1));
         @(posedge clk); #1;
         check("bist_cmd_wr", 64'({mem_cs, mem_we, mem_addr, mem_din}), 64'({2'b11, ca, cd}));
         cmd_valid = 1'b0;
         ref_mem[ca] = cd;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      n_checks = 0; n_errors = 0; fault = 1'b0;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_data = '0;
      rsp_ready = 1'b0; bist_start = 1'b0;
      for (int a = 0; a < 8; a++) begin mem[a] = '0; ref_mem[a] = '0; end
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 check("reset_outs", outs(), 64'(0));
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_ready", 64'(cmd_ready), 64'(1));

      do_bist(1'b0, '0, '0);
      do_write(3'd3, 16'h1234);
      do_read(3'd3, 0);
      do_read(3'd3, 5);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) do_write(AW'($urandom), DW'($urandom));
         else do_read(AW'($urandom), int'($urandom_range(0, 3)));
      end

      fault = 1'b1;
      do_bist(1'b0, '0, '0);
      fault = 1'b0;
      do_write(3'd1, 16'hBEEF);
      check("fail_sticky", 64'({bist_fail, fail_addr}), 64'({1'b1, 3'd5}));

      do_bist(1'b1, 3'd6, 16'hC0DE);
      do_read(3'd6, 1);

      bist_start = 1'b1;
      repeat (4) begin @(posedge clk); #1; bist_start = 1'b0; end
      check("rst_pre_we", 64'({bist_busy, mem_we}), 64'(2'b11));
      #1 rst_n = 1'b0;
      #1 check("rst_mid_outs", outs(), 64'(0));
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1 check("rst_release", 64'({cmd_ready, mem_cs, mem_we, bist_busy}), 64'(4'b1000));
      @(posedge clk); #1;

      do_bist(1'b0, '0, '0);
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 1) == 1) do_write(AW'($urandom), DW'($urandom));
         else do_read(AW'($urandom), int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_host_ctrl.md
MEM_HOST_CTRL -- requirements
Module: mem_host_ctrl

Interface
REQ-001 Parameter: ADDR_W, 3, memory address width (8 words).
REQ-002 Parameter: DATA_W, 16, memory word width.
REQ-003 Parameter: BIST_SEED, 16'hA5A5, base pattern for self-test.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  host request present.
REQ-007 cmd_ready  output  1  controller can accept a request.
REQ-008 cmd_we  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  target word address.
REQ-010 cmd_data  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  read data available.
REQ-012 rsp_ready  input  1  host accepts read data.
REQ-013 rsp_data  output  DATA_W  read data.
REQ-014 bist_start  input  1  single-cycle self-test request.
REQ-015 bist_busy / bist_done / bist_fail  output  1 each  self-test status; bist_done is a one-cycle pulse, bist_fail is sticky.
REQ-016 fail_addr  output  ADDR_W  address of the first failing word.
REQ-017 mem_cs, mem_we  output  1 each  memory select and write strobe.
REQ-018 mem_addr / mem_din  output  ADDR_W / DATA_W  memory address and write data.
REQ-019 mem_dout  input  DATA_W  memory read data, valid one cycle after mem_addr is presented with mem_we=0.

Function
REQ-020 States SHALL be IDLE, WR, RD_ADDR, RD_CAP, RSP, BIST_WR, BIST_RD, BIST_CMP, BIST_END.
REQ-021 cmd_ready SHALL be 1 only in IDLE when bist_start=0.
REQ-022 Handshake (cmd_valid & cmd_ready) in cycle N SHALL register cmd_we, cmd_addr and cmd_data.
REQ-023 Write: cycle N+1 in WR with mem_cs=1, mem_we=1, mem_addr/mem_din = registered values; return to IDLE (cmd_ready=1 at N+2); no response is generated.
REQ-024 Read: cycle N+1 in RD_ADDR with mem_cs=1, mem_we=0; N+2 RD_CAP captures mem_dout into rsp_data; N+3 RSP with rsp_valid=1.
REQ-025 rsp_valid and rsp_data SHALL hold stable until rsp_ready=1; the cycle after rsp_valid & rsp_ready, state returns to IDLE.
REQ-026 mem_we SHALL be 1 only in WR or BIST_WR; mem_cs SHALL be 0 in IDLE, RSP and BIST_END.
REQ-027 Simultaneous bist_start and cmd_valid in IDLE: self-test SHALL win and the command SHALL not be accepted.
REQ-028 bist_start outside IDLE SHALL be ignored.
REQ-029 Pattern P(a) = BIST_SEED XOR zero-extended a; pass 0 writes/checks P(a), pass 1 writes/checks ~P(a).
REQ-030 Each pass: BIST_WR for addresses 0..7 (one per cycle), then addresses 0..7 read with BIST_RD (address) followed by BIST_CMP (compare).
REQ-031 A clean run SHALL take exactly 48 cycles in BIST states; BIST_END SHALL pulse bist_done in cycle 49 after acceptance; bist_busy=1 from acceptance through the last BIST_CMP.
REQ-032 On the first mismatch, bist_fail=1 and fail_addr=a, and the run SHALL go directly to BIST_END.
REQ-033 bist_fail and fail_addr SHALL clear on the next accepted bist_start.
REQ-034 The address counter SHALL wrap 7->0 at each phase change without extra cycles.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE and drive cmd_ready=0, rsp_valid=0, rsp_data=0, mem_cs=0, mem_we=0, mem_addr=0, mem_din=0, bist_busy=0, bist_done=0, bist_fail=0, fail_addr=0.
REQ-036 A reset during a write or self-test SHALL drop mem_we asynchronously; the first cycle after release is IDLE with cmd_ready=1.

Structure
REQ-037 A shared package mem_pkg SHALL hold ADDR_W, DATA_W, BIST_SEED and the state enumeration.
REQ-038 The pattern function SHALL be one combinational sub-module, mem_pattern_gen (inputs address and pass; output word).

Verification
REQ-039 Write addr 3 data 16'h1234, then read addr 3 -> rsp_valid 3 cycles after read accept, rsp_data=16'h1234.
REQ-040 Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stay stable; cmd_ready stays 0 until the cycle after the handshake.
REQ-041 bist_start with a good memory model -> bist_busy for 48 cycles, bist_done pulse at cycle 49, bist_fail=0.
REQ-042 Memory model with bit 0 of addr 5 stuck-at-1 -> bist_fail=1, fail_addr=5, bist_done during pass 0.
REQ-043 bist_start and cmd_valid in the same cycle -> self-test runs and the command is accepted only after bist_done.
REQ-044 rst_n asserted mid-BIST_WR -> mem_we=0 immediately, all outputs at reset values, IDLE after release.
